// File: rtl/enc_iter_pkg.sv
// Shared definitions for the iterative SPN cipher: block geometry, FSM states,
// the bit permutation and the per-round key schedule.
package cipher_pkg;

  localparam int BLOCK_W = 16;
  localparam int NIBBLES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit i moves to (4*i) mod 15; the top bit is a fixed point.
  function automatic logic [BLOCK_W-1:0] perm(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < BLOCK_W - 1; i++) begin
      y[(4 * i) % (BLOCK_W - 1)] = x[i];
    end
    y[BLOCK_W-1] = x[BLOCK_W-1];
    return y;
  endfunction

  function automatic logic [BLOCK_W-1:0] key_next(input logic [BLOCK_W-1:0] kr,
                                                  input logic [3:0]         cnt);
    return {kr[BLOCK_W-5:0], kr[BLOCK_W-1:BLOCK_W-4]} ^ {12'b0, cnt + 4'd1};
  endfunction

endpackage

// File: rtl/enc_iter_if.sv
// Request/acknowledge bus carrying plaintext and key in, ciphertext out.
interface enc_iter_if;
  import cipher_pkg::*;

  logic               req;
  logic [BLOCK_W-1:0] m;
  logic [BLOCK_W-1:0] k;
  logic               ack;
  logic [BLOCK_W-1:0] r;

  modport master (output req, output m, output k, input ack, input r);
  modport slave  (input req, input m, input k, output ack, output r);
endinterface

// File: rtl/enc_iter_round_func.sv
// Combinational cipher round (key add, nibble substitution, bit permutation)
// and the 4-bit substitution box it uses.
module sbox (
  input  logic [3:0] a,
  output logic [3:0] y
);
  always_comb begin
    y = 4'h0;
    case (a)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
  end
endmodule

module round_func
  import cipher_pkg::*;
(
  input  logic [BLOCK_W-1:0] st,
  input  logic [BLOCK_W-1:0] kr,
  output logic [BLOCK_W-1:0] next_st
);
  logic [BLOCK_W-1:0] mixed;
  logic [BLOCK_W-1:0] subst;

  assign mixed = st ^ kr;

  for (genvar i = 0; i < NIBBLES; i++) begin : g_sbox
    sbox u_sbox (
      .a (mixed[4*i+3:4*i]),
      .y (subst[4*i+3:4*i])
    );
  end

  assign next_st = perm(subst);
endmodule

// File: rtl/enc_iter.sv
// Iterative encryption core: loads plaintext and key on request, runs one
// round per clock, then holds the ciphertext until the request is withdrawn.
module enc_iter
  import cipher_pkg::*;
#(
  parameter int ROUNDS = 4
) (
  input  logic       clk,
  input  logic       rst,
  enc_iter_if.slave  bus
);
  localparam logic [3:0] LAST = 4'(ROUNDS);

  state_t             state;
  state_t             state_nxt;
  logic [BLOCK_W-1:0] st;
  logic [BLOCK_W-1:0] kr;
  logic [BLOCK_W-1:0] r_q;
  logic [3:0]         cnt;
  logic               ack_q;
  logic [BLOCK_W-1:0] round_out;
  logic [BLOCK_W-1:0] kr_nxt;
  logic               last;

  round_func u_round (
    .st      (st),
    .kr      (kr),
    .next_st (round_out)
  );

  assign kr_nxt = key_next(kr, cnt);
  assign last   = (cnt + 4'd1) == LAST;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req)  state_nxt = RUN;
      RUN:     if (last)     state_nxt = DONE;
      DONE:    if (!bus.req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      st    <= '0;
      kr    <= '0;
      cnt   <= 4'd0;
      r_q   <= '0;
      ack_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.req) begin
            st  <= bus.m;
            kr  <= bus.k;
            cnt <= 4'd0;
          end
        end
        RUN: begin
          st  <= round_out;
          kr  <= kr_nxt;
          cnt <= cnt + 4'd1;
          // Final round folds in the post-whitening key in the same cycle.
          if (last) begin
            r_q   <= round_out ^ kr_nxt;
            ack_q <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.req) ack_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ack = ack_q;
  assign bus.r   = r_q;
endmodule

// File: tb/tb_enc_iter.sv
// Scoreboard bench for enc_iter: stimulus pushes expected ciphertext and
// ack cycle, a monitor pops and compares on every rising ack.
module tb_enc_iter;

  typedef struct {
    logic [15:0] r;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  exp_t q1[$];
  exp_t q4[$];

  enc_iter_if bus1();
  enc_iter_if bus4();

  enc_iter #(.ROUNDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  enc_iter #(.ROUNDS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model(input logic [15:0] m, input logic [15:0] k,
                                        input int rounds);
    logic [3:0]  sb [16];
    logic [15:0] st, kr, s, p;
    sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    st = m;
    kr = k;
    for (int c = 0; c < rounds; c++) begin
      s = st ^ kr;
      for (int n = 0; n < 4; n++) s[4*n +: 4] = sb[s[4*n +: 4]];
      p = 16'h0;
      for (int i = 0; i < 15; i++) p[(4 * i) % 15] = s[i];
      p[15] = s[15];
      st = p;
      kr = {kr[11:0], kr[15:12]} ^ 16'(c + 1);
    end
    return st ^ kr;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%04h want=0x%04h cycle=%0d", name, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares ciphertext and ack timing on each rising ack.
  initial begin
    logic a1_d, a4_d;
    exp_t e;
    a1_d = 1'b0;
    a4_d = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus4.ack === 1'b1 && a4_d !== 1'b1) begin
        checks++;
        if (q4.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ack4 got=ack want=no_ack cycle=%0d", cyc);
        end else begin
          e = q4.pop_front();
          if (bus4.r !== e.r) begin
            failures++;
            $display("FAIL r4 got=0x%04h want=0x%04h cycle=%0d", bus4.r, e.r, cyc);
          end
          checks++;
          if (cyc != e.cyc) begin
            failures++;
            $display("FAIL ack4_latency got=%0d want=%0d", cyc, e.cyc);
          end
        end
      end
      if (bus1.ack === 1'b1 && a1_d !== 1'b1) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ack1 got=ack want=no_ack cycle=%0d", cyc);
        end else begin
          e = q1.pop_front();
          if (bus1.r !== e.r) begin
            failures++;
            $display("FAIL r1 got=0x%04h want=0x%04h cycle=%0d", bus1.r, e.r, cyc);
          end
          checks++;
          if (cyc != e.cyc) begin
            failures++;
            $display("FAIL ack1_latency got=%0d want=%0d", cyc, e.cyc);
          end
        end
      end
      a1_d = bus1.ack;
      a4_d = bus4.ack;
    end
  end

  // Raise req just after an edge; the next edge is the load edge.
  task automatic start4(input logic [15:0] mm, input logic [15:0] kk,
                        input logic [15:0] er, input bit push);
    bus4.m   = mm;
    bus4.k   = kk;
    bus4.req = 1'b1;
    if (push) q4.push_back('{er, cyc + 1 + 4});
  endtask

  task automatic wait_ack4(input logic level);
    int n;
    n = 0;
    while (bus4.ack !== level && n < 20) begin
      tick();
      n++;
    end
    if (bus4.ack !== level) begin
      checks++;
      failures++;
      $display("FAIL ack4_timeout got=%b want=%b cycle=%0d", bus4.ack, level, cyc);
    end
  endtask

  task automatic run4(input logic [15:0] mm, input logic [15:0] kk, input logic [15:0] er);
    start4(mm, kk, er, 1'b1);
    tick();
    wait_ack4(1'b1);
    bus4.req = 1'b0;
    wait_ack4(1'b0);
  endtask

  initial begin
    logic [15:0] ma, ka, ra, mb, kb;
    int n;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus1.req = 1'b0; bus1.m = 16'h0; bus1.k = 16'h0;
    bus4.req = 1'b0; bus4.m = 16'h0; bus4.k = 16'h0;
    repeat (3) tick();
    check("reset_ack1", {15'b0, bus1.ack}, 16'h0);
    check("reset_r1", bus1.r, 16'h0);
    check("reset_ack4", {15'b0, bus4.ack}, 16'h0);
    check("reset_r4", bus4.r, 16'h0);
    rst = 1'b0;
    tick();

    // ROUNDS=1, all-zero inputs, req held high through DONE.
    bus1.req = 1'b1;
    q1.push_back('{16'hFF01, cyc + 1 + 1});
    n = 0;
    tick();
    while (bus1.ack !== 1'b1 && n < 10) begin tick(); n++; end
    repeat (2) begin
      tick();
      check("r1_hold_ack", {15'b0, bus1.ack}, 16'h1);
      check("r1_hold_r", bus1.r, 16'hFF01);
    end
    bus1.req = 1'b0;
    tick();
    check("r1_ack_fall", {15'b0, bus1.ack}, 16'h0);
    check("r1_r_kept", bus1.r, 16'hFF01);

    // ROUNDS=4, all-zero inputs, hand-computed.
    run4(16'h0000, 16'h0000, 16'h4017);
    run4(16'h1234, 16'hABCD, model(16'h1234, 16'hABCD, 4));
    run4(16'hFFFF, 16'hFFFF, model(16'hFFFF, 16'hFFFF, 4));

    // req dropped right after the load edge: one-cycle ack pulse.
    start4(16'hBEEF, 16'h0F1E, model(16'hBEEF, 16'h0F1E, 4), 1'b1);
    tick();
    bus4.req = 1'b0;
    repeat (3) tick();
    check("drop_ack_early", {15'b0, bus4.ack}, 16'h0);
    tick();
    check("drop_ack_high", {15'b0, bus4.ack}, 16'h1);
    tick();
    check("drop_ack_low", {15'b0, bus4.ack}, 16'h0);
    // Back in IDLE: a request issued now must load on the next edge.
    start4(16'h5A5A, 16'hC3C3, model(16'h5A5A, 16'hC3C3, 4), 1'b1);
    tick();
    wait_ack4(1'b1);
    bus4.req = 1'b0;
    wait_ack4(1'b0);

    // m/k change after load must not affect the result.
    start4(16'h0F0F, 16'h7777, model(16'h0F0F, 16'h7777, 4), 1'b1);
    tick();
    bus4.m = 16'hFFFF;
    bus4.k = 16'hFFFF;
    wait_ack4(1'b1);
    bus4.req = 1'b0;
    wait_ack4(1'b0);

    // Reset during the second round edge discards the computation.
    start4(16'h2468, 16'h1357, 16'h0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_ack", {15'b0, bus4.ack}, 16'h0);
    check("midrst_r", bus4.r, 16'h0);
    rst = 1'b0;
    bus4.req = 1'b0;
    repeat (6) tick();
    check("midrst_no_ack", {15'b0, bus4.ack}, 16'h0);
    run4(16'h2468, 16'h1357, model(16'h2468, 16'h1357, 4));

    // Back-to-back: r holds the first result until the second ack.
    ma = 16'hCAFE; ka = 16'h0123;
    mb = 16'h8001; kb = 16'hFEDC;
    ra = model(ma, ka, 4);
    run4(ma, ka, ra);
    start4(mb, kb, model(mb, kb, 4), 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus4.ack !== 1'b1) check("b2b_r_hold", bus4.r, ra);
    end
    wait_ack4(1'b1);
    bus4.req = 1'b0;
    wait_ack4(1'b0);

    // Random pairs against the model.
    for (int i = 0; i < 256; i++) begin
      ma = 16'($urandom);
      ka = 16'($urandom);
      run4(ma, ka, model(ma, ka, 4));
    end

    repeat (8) tick();
    check("q4_drained", 16'(q4.size()), 16'h0);
    check("q1_drained", 16'(q1.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
